dram_cmd_sequencer: RTL and testbench

- Downstream stage of the request queue and address mapper in the DDR5 scheduler.
- Accepts one mapped request at a time over a valid/ready handshake.
- Issues the DDR5 command sequence for that request with timing gaps enforced: ACT0, ACT1, RD0/WR0, RD1/WR1, PRE.
- Also issues REF on request. Each issued command is a single-cycle pulse that feeds the output-file logger.

---
 rtl/dram_cmd_sequencer_pkg.sv | 46 ++++
 rtl/dram_cmd_sequencer_wait_timer.sv | 22 ++
 rtl/dram_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_dram_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_cmd_sequencer_pkg.sv
// Shared types and constants for the DDR5 command sequencer.
// Holds the command encodings, the mapped-address layout and the default timings.
package dram_cmd_sequencer_pkg;

  localparam int unsigned T_CMD_DEF   = 2;
  localparam int unsigned T_RCD_DEF   = 78;
  localparam int unsigned T_RTP_DEF   = 36;
  localparam int unsigned T_WRPRE_DEF = 152;
  localparam int unsigned T_RP_DEF    = 78;
  localparam int unsigned T_RFC_DEF   = 590;
  localparam int unsigned CNT_W_DEF   = 10;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_IFETCH = 2'd2;

  typedef enum logic [2:0] {
    CMD_ACT0 = 3'd0,
    CMD_ACT1 = 3'd1,
    CMD_RD0  = 3'd2,
    CMD_RD1  = 3'd3,
    CMD_WR0  = 3'd4,
    CMD_WR1  = 3'd5,
    CMD_PRE  = 3'd6,
    CMD_REF  = 3'd7
  } commands;

  typedef struct packed {
    logic [15:0] row;
    logic [5:0]  col_high;
    logic [1:0]  bank;
    logic [2:0]  bank_group;
    logic        channel;
    logic [5:0]  col_low;
  } add_map;

  function automatic add_map address_mapping(input logic [33:0] addr);
    return add_map'(addr);
  endfunction

  // Column address is the 8-bit {col_high, col_low[5:4]} zero-extended.
  function automatic logic [15:0] column_of(input add_map m);
    return {8'd0, m.col_high, m.col_low[5:4]};
  endfunction

endpackage

// File: rtl/dram_cmd_sequencer_wait_timer.sv
// Loadable down-counter that stops at zero and flags it.
module seq_wait_timer #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)               r_cnt <= '0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Issues ACT0/ACT1/RD|WR0/RD|WR1/PRE for one mapped request, or REF, with timing gaps.
// Command outputs are registered, so each command appears the cycle after its transition.
module dram_cmd_sequencer
  import dram_cmd_sequencer_pkg::*;
#(
  parameter int unsigned T_CMD   = T_CMD_DEF,
  parameter int unsigned T_RCD   = T_RCD_DEF,
  parameter int unsigned T_RTP   = T_RTP_DEF,
  parameter int unsigned T_WRPRE = T_WRPRE_DEF,
  parameter int unsigned T_RP    = T_RP_DEF,
  parameter int unsigned T_RFC   = T_RFC_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [33:0] req_addr,
  input  logic        ref_req,
  output logic        ref_ack,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_addr,
  output logic        cmd_is_col,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, ACT0, ACT1, COL0, COL1, PRE, PRE_WAIT, REF, REF_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] L_RCD   = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] L_RTP   = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] L_WRPRE = CNT_W'(T_WRPRE - 1);
  localparam logic [CNT_W-1:0] L_RP    = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] L_RFC   = CNT_W'(T_RFC - 1);

  state_e           r_state, w_next;
  commands          w_cmd;
  logic             w_issue, w_done, w_ack, w_accept, w_zero;
  logic [CNT_W-1:0] w_load_val;
  add_map           w_map, r_map, w_src;
  logic             r_wr;

  assign w_map     = address_mapping(req_addr);
  assign req_ready = (r_state == IDLE) && !ref_req;
  assign w_accept  = req_ready && req_valid;
  assign w_src     = (r_state == IDLE) ? w_map : r_map;

  seq_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_load     (w_issue),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    w_cmd      = CMD_ACT0;
    w_load_val = '0;
    w_done     = 1'b0;
    w_ack      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ref_req) begin
          w_next = REF; w_issue = 1'b1; w_cmd = CMD_REF; w_load_val = L_RFC; w_ack = 1'b1;
        end else if (req_valid) begin
          w_next = ACT0; w_issue = 1'b1; w_cmd = CMD_ACT0; w_load_val = L_CMD;
        end
      end
      ACT0: if (w_zero) begin
        w_next = ACT1; w_issue = 1'b1; w_cmd = CMD_ACT1; w_load_val = L_RCD;
      end
      ACT1: if (w_zero) begin
        w_next = COL0; w_issue = 1'b1; w_cmd = r_wr ? CMD_WR0 : CMD_RD0; w_load_val = L_CMD;
      end
      COL0: if (w_zero) begin
        w_next = COL1; w_issue = 1'b1; w_cmd = r_wr ? CMD_WR1 : CMD_RD1;
        w_load_val = r_wr ? L_WRPRE : L_RTP;
      end
      COL1: if (w_zero) begin
        w_next = PRE; w_issue = 1'b1; w_cmd = CMD_PRE; w_load_val = L_RP;
      end
      // A gap of 1 expires in the issue state itself, so it may retire directly.
      PRE:      if (w_zero) begin w_next = IDLE; w_done = 1'b1; end else w_next = PRE_WAIT;
      PRE_WAIT: if (w_zero) begin w_next = IDLE; w_done = 1'b1; end
      REF:      if (w_zero) begin w_next = IDLE; w_done = 1'b1; end else w_next = REF_WAIT;
      REF_WAIT: if (w_zero) begin w_next = IDLE; w_done = 1'b1; end
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_map <= '0;
      r_wr  <= 1'b0;
    end else if (w_accept) begin
      r_map <= w_map;
      r_wr  <= (req_op == OP_WRITE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      ref_ack     <= 1'b0;
      done        <= 1'b0;
      cmd_type    <= CMD_ACT0;
      cmd_channel <= 1'b0;
      cmd_bg      <= '0;
      cmd_bank    <= '0;
      cmd_addr    <= '0;
      cmd_is_col  <= 1'b0;
    end else begin
      cmd_valid <= w_issue;
      ref_ack   <= w_ack;
      done      <= w_done;
      if (w_issue) begin
        cmd_type <= w_cmd;
        if (w_cmd != CMD_REF) begin
          cmd_channel <= w_src.channel;
          cmd_bg      <= w_src.bank_group;
          cmd_bank    <= w_src.bank;
        end
        unique case (w_cmd)
          CMD_ACT0, CMD_ACT1: begin cmd_addr <= w_src.row;        cmd_is_col <= 1'b0; end
          CMD_PRE, CMD_REF:   begin cmd_addr <= '0;               cmd_is_col <= 1'b0; end
          default:            begin cmd_addr <= column_of(w_src); cmd_is_col <= 1'b1; end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer: vector table of single requests plus
// hand-written refresh-priority, back-to-back and mid-sequence reset sequences.
module tb_dram_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [33:0] req_addr;
  logic        ref_req;
  logic        ref_ack;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic        cmd_channel;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_addr;
  logic        cmd_is_col;
  logic        done;

  dram_cmd_sequencer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .ref_req(ref_req), .ref_ack(ref_ack),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_channel(cmd_channel),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
    .cmd_is_col(cmd_is_col), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [2:0]  typ;
    logic [15:0] addr;
    logic        is_col;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic        ch;
  } ev_t;

  ev_t  evq[$];
  int   doneq[$];
  int   ackq[$];
  int   base = 0;
  int   b2b_viol = 0;
  logic prev_v = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clock) begin
    if (cmd_valid) evq.push_back('{cyc - base, cmd_type, cmd_addr, cmd_is_col, cmd_bg, cmd_bank, cmd_channel});
    if (done)      doneq.push_back(cyc - base);
    if (ref_ack)   ackq.push_back(cyc - base);
    if (cmd_valid && prev_v) b2b_viol++;
    prev_v = cmd_valid;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t get_ev(input int i);
    ev_t e;
    e = '{-1, 3'd0, 16'd0, 1'b0, 3'd0, 2'd0, 1'b0};
    if (i < evq.size()) e = evq[i];
    return e;
  endfunction

  function automatic int get_q(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_mon();
    evq.delete(); doneq.delete(); ackq.delete();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [33:0] addr;
    logic [15:0] row;
    logic [15:0] col;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic        ch;
    logic [2:0]  c0;
    logic [2:0]  c1;
    int          pre_t;
    int          done_t;
  } vec_t;

  vec_t vecs[4];

  task automatic run_row(input int r);
    vec_t v;
    ev_t  e;
    int   exp_t[5];
    logic [2:0]  exp_typ[5];
    logic [15:0] exp_addr[5];
    logic        exp_col[5];
    v = vecs[r];
    exp_t    = '{1, 3, 81, 83, v.pre_t};
    exp_typ  = '{3'd0, 3'd1, v.c0, v.c1, 3'd6};
    exp_addr = '{v.row, v.row, v.col, v.col, 16'h0000};
    exp_col  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    clear_mon();
    @(negedge clock);
    base = cyc;
    check($sformatf("row%0d ready", r), {63'd0, req_ready}, 64'd1);
    req_op = v.op; req_addr = v.addr; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (330) @(negedge clock);
    check($sformatf("row%0d ncmd", r), evq.size(), 64'd5);
    for (int i = 0; i < 5; i++) begin
      e = get_ev(i);
      check($sformatf("row%0d cmd%0d time", r, i), e.t, exp_t[i]);
      check($sformatf("row%0d cmd%0d type", r, i), {61'd0, e.typ}, {61'd0, exp_typ[i]});
      check($sformatf("row%0d cmd%0d addr", r, i), {48'd0, e.addr}, {48'd0, exp_addr[i]});
      check($sformatf("row%0d cmd%0d is_col", r, i), {63'd0, e.is_col}, {63'd0, exp_col[i]});
    end
    e = get_ev(0);
    check($sformatf("row%0d bg/bank/ch", r), {58'd0, e.bg, e.bank, e.ch}, {58'd0, v.bg, v.bank, v.ch});
    check($sformatf("row%0d done", r), get_q(doneq, 0), v.done_t);
  endtask

  initial begin
    ev_t e;
    int  acc;
    int  na;
    int  acc_t[2];
    int  npre;

    vecs[0] = '{2'd0, 34'h123456789, 16'h48D1, 16'h0058, 3'd7, 2'd1, 1'b0, 3'd2, 3'd3, 119, 197};
    vecs[1] = '{2'd1, 34'h123456789, 16'h48D1, 16'h0058, 3'd7, 2'd1, 1'b0, 3'd4, 3'd5, 235, 313};
    vecs[2] = '{2'd2, {16'hBEEF, 6'h2A, 2'd2, 3'd3, 1'b1, 6'h35}, 16'hBEEF, 16'h00AB, 3'd3, 2'd2, 1'b1,
                3'd2, 3'd3, 119, 197};
    vecs[3] = '{2'd3, {16'h0001, 6'h3F, 2'd3, 3'd0, 1'b1, 6'h0F}, 16'h0001, 16'h00FC, 3'd0, 2'd3, 1'b1,
                3'd2, 3'd3, 119, 197};

    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; ref_req = 1'b0;
    repeat (3) @(negedge clock);
    check("reset outputs", {31'd0, cmd_valid, ref_ack, done, cmd_type, cmd_channel, cmd_bg, cmd_bank,
                            cmd_addr, cmd_is_col}, 64'd0);
    check("reset ready", {63'd0, req_ready}, 64'd1);
    reset = 1'b0;

    for (int r = 0; r < 4; r++) run_row(r);

    // Refresh wins over a simultaneous request; request waits for refresh to retire.
    clear_mon();
    @(negedge clock);
    base = cyc;
    ref_req = 1'b1; req_valid = 1'b1; req_op = 2'd0; req_addr = 34'h123456789;
    #1 check("prio ready low", {63'd0, req_ready}, 64'd0);
    acc = -1;
    for (int k = 0; k < 800 && acc < 0; k++) begin
      @(negedge clock);
      if (ref_ack) ref_req = 1'b0;
      if (req_valid && req_ready) acc = cyc - base;
    end
    @(negedge clock);
    req_valid = 1'b0;
    repeat (210) @(negedge clock);
    check("prio ref_ack", get_q(ackq, 0), 1);
    e = get_ev(0);
    check("prio REF time", e.t, 1);
    check("prio REF type/addr", {44'd0, e.typ, e.addr, e.is_col}, {44'd0, 3'd7, 16'd0, 1'b0});
    check("prio ref done", get_q(doneq, 0), 591);
    check("prio accept", acc, 591);
    e = get_ev(1);
    check("prio ACT0 time", e.t, 592);
    check("prio ACT0 type", {61'd0, e.typ}, 64'd0);
    check("prio read done", get_q(doneq, 1), 788);

    // Two reads with req_valid held: second accepted in the first done cycle.
    clear_mon();
    @(negedge clock);
    base = cyc;
    req_valid = 1'b1; req_op = 2'd0; req_addr = 34'h123456789;
    na = 0; acc_t = '{-1, -1};
    for (int k = 0; k < 600 && na < 2; k++) begin
      if (req_ready) begin acc_t[na] = cyc - base; na++; end
      @(negedge clock);
    end
    req_valid = 1'b0;
    repeat (220) @(negedge clock);
    check("b2b accept0", acc_t[0], 0);
    check("b2b accept1", acc_t[1], 197);
    check("b2b ncmd", evq.size(), 64'd10);
    e = get_ev(0);
    check("b2b ACT0 #1", e.t, 1);
    e = get_ev(5);
    check("b2b ACT0 #2 time", e.t, 198);
    check("b2b ACT0 #2 type", {61'd0, e.typ}, 64'd0);
    check("b2b done0", get_q(doneq, 0), 197);
    check("b2b done1", get_q(doneq, 1), 394);

    // Reset mid-sequence: request is dropped without a PRE.
    clear_mon();
    @(negedge clock);
    base = cyc;
    req_valid = 1'b1; req_op = 2'd0; req_addr = 34'h123456789;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (49) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst cycle", cyc - base, 51);
    check("midrst outputs", {31'd0, cmd_valid, ref_ack, done, cmd_type, cmd_channel, cmd_bg, cmd_bank,
                             cmd_addr, cmd_is_col}, 64'd0);
    check("midrst ready", {63'd0, req_ready}, 64'd1);
    reset = 1'b0;
    repeat (250) @(negedge clock);
    npre = 0;
    foreach (evq[i]) if (evq[i].typ == 3'd6) npre++;
    check("midrst no PRE", npre, 0);
    check("midrst ncmd", evq.size(), 64'd2);
    check("midrst no done", doneq.size(), 64'd0);
    run_row(0);

    check("no back-to-back cmd_valid", b2b_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
